// File: rtl/dcache_assoc.sv
// dcache_assoc: 2-way set-associative, write-back, write-allocate data cache.
// Sits between the CPU load/store port (one word per access) and a block-wide
// data memory. Hits complete with zero wait states. Replacement uses one LRU
// bit per set. A flush request writes back every dirty line.
//
// Ports
//   clock, reset        rising-edge clock, asynchronous active-low reset
//   read, write         CPU request levels, held until busywait is low
//   address, writedata  CPU {tag, index, offset} address and store data
//   readdata, busywait  load data (combinational on hit) and CPU stall
//   flush, flush_done   flush request level / one-cycle completion pulse
//   mem_read/mem_write  block transfer requests to memory
//   mem_address         block address {tag, index}
//   mem_writedata       victim block being written back
//   mem_readdata        fetched block
//   mem_busywait        memory stall; a transfer completes on the first
//                       posedge where this is low while a request is high
module dcache_assoc #(
    parameter int ADDR_W = 8,
    parameter int WORD_W = 8,
    parameter int WORDS  = 4,
    parameter int SETS   = 4
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            read,
    input  logic                            write,
    input  logic [ADDR_W-1:0]               address,
    input  logic [WORD_W-1:0]               writedata,
    output logic [WORD_W-1:0]               readdata,
    output logic                            busywait,
    input  logic                            flush,
    output logic                            flush_done,
    output logic                            mem_read,
    output logic                            mem_write,
    output logic [ADDR_W-$clog2(WORDS)-1:0] mem_address,
    output logic [WORD_W*WORDS-1:0]         mem_writedata,
    input  logic [WORD_W*WORDS-1:0]         mem_readdata,
    input  logic                            mem_busywait
);
    localparam int OFF_W = $clog2(WORDS);
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = ADDR_W - IDX_W - OFF_W;
    localparam int BLK_W = WORD_W * WORDS;
    localparam int CNT_W = IDX_W + 1;
    localparam logic [CNT_W-1:0] LAST_ENTRY = CNT_W'(2 * SETS - 1);

    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_WBACK      = 3'd1;
    localparam logic [2:0] S_FETCH      = 3'd2;
    localparam logic [2:0] S_ALLOC      = 3'd3;
    localparam logic [2:0] S_FLUSH_SCAN = 3'd4;
    localparam logic [2:0] S_FLUSH_WB   = 3'd5;
    localparam logic [2:0] S_FLUSH_DONE = 3'd6;

    logic [2:0]                state_q, state_d;
    logic [SETS-1:0][1:0]      valid_q, valid_d;
    logic [SETS-1:0][1:0]      dirty_q, dirty_d;
    logic [SETS-1:0]           lru_q, lru_d;
    logic                      victim_q, victim_d;
    logic [CNT_W-1:0]          fcnt_q, fcnt_d;
    logic [ADDR_W-OFF_W-1:0]   maddr_q, maddr_d;
    logic [BLK_W-1:0]          mwdata_q, mwdata_d;

    // Tags, blocks and the fetch buffer are not reset; valid bits guard them.
    logic [TAG_W-1:0]          tag_q  [SETS][2];
    logic [BLK_W-1:0]          data_q [SETS][2];
    logic [BLK_W-1:0]          fetch_q;

    logic [TAG_W-1:0]          req_tag;
    logic [IDX_W-1:0]          req_idx;
    logic [OFF_W-1:0]          req_off;
    logic                      req;
    logic [1:0]                hit_way;
    logic                      hit;
    logic                      hit_w;
    logic                      wr_hit;
    logic                      vict;
    logic [BLK_W-1:0]          hit_blk;
    logic [IDX_W-1:0]          fset;
    logic                      fway;

    assign req_tag = address[ADDR_W-1 -: TAG_W];
    assign req_idx = address[OFF_W +: IDX_W];
    assign req_off = address[OFF_W-1:0];
    assign req     = read | write;

    always_comb begin
        for (int w = 0; w < 2; w++)
            hit_way[w] = valid_q[req_idx][w] && (tag_q[req_idx][w] == req_tag);
    end

    // A tag can live in only one way of a set, so way1's match bit picks the way.
    assign hit     = |hit_way;
    assign hit_w   = hit_way[1];
    assign hit_blk = data_q[req_idx][hit_w];
    assign wr_hit  = (state_q == S_IDLE) && write && hit;

    // Fill an empty way first (way0 preferred), else evict the LRU way.
    assign vict = !valid_q[req_idx][0] ? 1'b0 :
                  !valid_q[req_idx][1] ? 1'b1 : lru_q[req_idx];

    assign fset = fcnt_q[CNT_W-1:1];
    assign fway = fcnt_q[0];

    always_comb begin
        state_d  = state_q;
        valid_d  = valid_q;
        dirty_d  = dirty_q;
        lru_d    = lru_q;
        victim_d = victim_q;
        fcnt_d   = fcnt_q;
        maddr_d  = maddr_q;
        mwdata_d = mwdata_q;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    if (hit) begin
                        lru_d[req_idx] = ~hit_w;
                        if (write) dirty_d[req_idx][hit_w] = 1'b1;
                    end else begin
                        victim_d = vict;
                        if (valid_q[req_idx][vict] && dirty_q[req_idx][vict]) begin
                            state_d  = S_WBACK;
                            maddr_d  = {tag_q[req_idx][vict], req_idx};
                            mwdata_d = data_q[req_idx][vict];
                        end else begin
                            state_d = S_FETCH;
                            maddr_d = {req_tag, req_idx};
                        end
                    end
                end else if (flush) begin
                    state_d = S_FLUSH_SCAN;
                    fcnt_d  = '0;
                end
            end
            S_WBACK: begin
                if (!mem_busywait) begin
                    dirty_d[req_idx][victim_q] = 1'b0;
                    state_d = S_FETCH;
                    maddr_d = {req_tag, req_idx};
                end
            end
            S_FETCH: begin
                if (!mem_busywait) state_d = S_ALLOC;
            end
            S_ALLOC: begin
                valid_d[req_idx][victim_q] = 1'b1;
                dirty_d[req_idx][victim_q] = 1'b0;
                state_d = S_IDLE;
            end
            S_FLUSH_SCAN: begin
                if (valid_q[fset][fway] && dirty_q[fset][fway]) begin
                    state_d  = S_FLUSH_WB;
                    maddr_d  = {tag_q[fset][fway], fset};
                    mwdata_d = data_q[fset][fway];
                end else if (fcnt_q == LAST_ENTRY) begin
                    state_d = S_FLUSH_DONE;
                end else begin
                    fcnt_d = fcnt_q + 1'b1;
                end
            end
            S_FLUSH_WB: begin
                // Re-scan the same entry; it is now clean, so the scan advances.
                if (!mem_busywait) begin
                    dirty_d[fset][fway] = 1'b0;
                    state_d = S_FLUSH_SCAN;
                end
            end
            S_FLUSH_DONE: begin
                fcnt_d  = '0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            valid_q  <= '0;
            dirty_q  <= '0;
            lru_q    <= '0;
            victim_q <= 1'b0;
            fcnt_q   <= '0;
            maddr_q  <= '0;
            mwdata_q <= '0;
        end else begin
            state_q  <= state_d;
            valid_q  <= valid_d;
            dirty_q  <= dirty_d;
            lru_q    <= lru_d;
            victim_q <= victim_d;
            fcnt_q   <= fcnt_d;
            maddr_q  <= maddr_d;
            mwdata_q <= mwdata_d;
        end
    end

    always_ff @(posedge clock) begin
        if (wr_hit)
            data_q[req_idx][hit_w][req_off*WORD_W +: WORD_W] <= writedata;
        if (state_q == S_ALLOC) begin
            data_q[req_idx][victim_q] <= fetch_q;
            tag_q[req_idx][victim_q]  <= req_tag;
        end
        if (state_q == S_FETCH && !mem_busywait)
            fetch_q <= mem_readdata;
    end

    // busywait is gated by reset so a reset mid-miss releases the CPU at once.
    assign busywait      = reset && ((state_q != S_IDLE) || (req && !hit));
    assign readdata      = (state_q == S_IDLE && read && hit) ?
                           hit_blk[req_off*WORD_W +: WORD_W] : '0;
    assign mem_read      = (state_q == S_FETCH);
    assign mem_write     = (state_q == S_WBACK) || (state_q == S_FLUSH_WB);
    assign flush_done    = (state_q == S_FLUSH_DONE);
    assign mem_address   = maddr_q;
    assign mem_writedata = mwdata_q;
endmodule

// File: tb/tb_dcache_assoc.sv
// Directed bench for dcache_assoc with a latency-programmable block memory,
// a byte-level reference image of the address space and a transfer log.
module tb_dcache_assoc;
    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        read = 1'b0, write = 1'b0, flush = 1'b0;
    logic [7:0]  address = '0, writedata = '0;
    logic [7:0]  readdata;
    logic        busywait, flush_done, mem_read, mem_write;
    logic [5:0]  mem_address;
    logic [31:0] mem_writedata, mem_readdata;
    logic        mem_busywait;

    dcache_assoc dut (
        .clock(clock), .reset(reset), .read(read), .write(write),
        .address(address), .writedata(writedata), .readdata(readdata),
        .busywait(busywait), .flush(flush), .flush_done(flush_done),
        .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
        .mem_writedata(mem_writedata), .mem_readdata(mem_readdata),
        .mem_busywait(mem_busywait)
    );

    always #5 clock = ~clock;

    int errs = 0, checks = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] pat(input int i);
        logic [7:0] b = 8'(i);
        if (i == 9) return 32'h44332211;
        return {b ^ 8'hC3, b + 8'h40, b ^ 8'h5A, b + 8'h80};
    endfunction

    // Reference byte image of memory as the CPU should see it.
    logic [7:0] refm [256];

    function automatic logic [31:0] refblk(input int b);
        return {refm[b*4+3], refm[b*4+2], refm[b*4+1], refm[b*4]};
    endfunction

    // Block memory: mem_lat busy cycles per transfer, completes when busywait low.
    typedef struct { bit wr; logic [5:0] addr; logic [31:0] data; } xfer_t;
    xfer_t       xlog [$];
    logic [31:0] mem [64];
    bit          mem_init_done = 1'b0;
    int          wait_cnt = 0;
    int          mem_lat = 0;

    always @(posedge clock) begin
        if (!mem_init_done) begin
            for (int i = 0; i < 64; i++) mem[i] <= pat(i);
            mem_init_done <= 1'b1;
        end
        if (mem_read || mem_write) begin
            if (wait_cnt == mem_lat) begin
                wait_cnt <= 0;
                if (mem_write) mem[mem_address] <= mem_writedata;
                xlog.push_back('{mem_write, mem_address, mem_write ? mem_writedata : mem_readdata});
            end else begin
                wait_cnt <= wait_cnt + 1;
            end
        end else begin
            wait_cnt <= 0;
        end
    end

    assign mem_busywait = (mem_read || mem_write) && (wait_cnt != mem_lat);
    assign mem_readdata = mem[mem_address];

    task automatic acc(input bit wr, input logic [7:0] a, input logic [7:0] wd,
                       output logic [7:0] rd, output int st);
        @(negedge clock);
        address = a; writedata = wd; read = !wr; write = wr;
        #1;
        st = 0;
        while (busywait && st < 300) begin
            @(negedge clock); #1; st++;
        end
        if (st >= 300) chk("acc_timeout", st, 0);
        rd = readdata;
        @(posedge clock); #1;
        read = 1'b0; write = 1'b0;
        if (wr) refm[a] = wd;
    endtask

    task automatic do_flush(output int pulses, output int bw_low);
        int cyc = 0;
        pulses = 0; bw_low = 0;
        @(negedge clock); flush = 1'b1;
        do begin
            @(negedge clock); #1; cyc++;
            if (!busywait) bw_low++;
        end while (!flush_done && cyc < 500);
        if (!flush_done) chk("flush_timeout", cyc, 0);
        if (flush_done) pulses++;
        @(posedge clock); #1; flush = 1'b0;
        repeat (4) begin
            @(negedge clock); #1;
            if (flush_done) pulses++;
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [7:0]  rd;
        logic [31:0] exp_blk;
        int st, base, pulses, bw_low, bad, cyc;
        bit wr;
        logic [7:0] a;

        for (int i = 0; i < 256; i++) refm[i] = pat(i / 4)[(i % 4)*8 +: 8];

        // Reset state
        repeat (2) @(posedge clock);
        #1;
        chk("rst_busywait", busywait, 0);
        chk("rst_flush_done", flush_done, 0);
        chk("rst_mem_read", mem_read, 0);
        chk("rst_mem_write", mem_write, 0);
        chk("rst_readdata", readdata, 0);
        chk("rst_mem_address", mem_address, 0);
        chk("rst_mem_writedata", mem_writedata, 0);
        @(negedge clock); reset = 1'b1;

        // Cold read miss, 3 busy cycles per transfer
        mem_lat = 3;
        base = xlog.size();
        acc(0, 8'h24, 8'h00, rd, st);
        chk("cold_stall", st, 6);
        chk("cold_data", rd, 8'h11);
        chk("cold_xfers", xlog.size() - base, 1);
        chk("cold_is_read", xlog[base].wr, 0);
        chk("cold_addr", xlog[base].addr, 6'h09);
        acc(0, 8'h27, 8'h00, rd, st);
        chk("hit_stall", st, 0);
        chk("hit_data", rd, 8'h44);

        // Write hit
        acc(1, 8'h25, 8'hAB, rd, st);
        chk("wrhit_stall", st, 0);
        acc(0, 8'h25, 8'h00, rd, st);
        chk("wrhit_rd_stall", st, 0);
        chk("wrhit_rd_data", rd, 8'hAB);
        chk("wrhit_dirty", dut.dirty_q[1][0], 1);

        // LRU eviction of a dirty way1
        mem_lat = 1;
        acc(0, 8'h54, 8'h00, rd, st);
        chk("fill5_stall", st, 4);
        chk("fill5_data", rd, refm[8'h54]);
        acc(1, 8'h55, 8'hCD, rd, st);
        chk("wr5_stall", st, 0);
        acc(0, 8'h24, 8'h00, rd, st);
        chk("touch2_stall", st, 0);
        mem_lat = 2;
        exp_blk = refblk(8'h15);
        base = xlog.size();
        acc(0, 8'h94, 8'h00, rd, st);
        chk("evict_stall", st, 8);
        chk("evict_data", rd, refm[8'h94]);
        chk("evict_xfers", xlog.size() - base, 2);
        chk("evict_wb_is_write", xlog[base].wr, 1);
        chk("evict_wb_addr", xlog[base].addr, 6'h15);
        chk("evict_wb_data", xlog[base].data, exp_blk);
        chk("evict_fetch_is_read", xlog[base+1].wr, 0);
        chk("evict_fetch_addr", xlog[base+1].addr, 6'h25);
        acc(0, 8'h24, 8'h00, rd, st);
        chk("tag2_kept", st, 0);

        // Flush with three dirty lines: (0,0), (1,0), (2,1)
        mem_lat = 0;
        acc(1, 8'h00, 8'h5E, rd, st);
        chk("lat0_stall", st, 3);
        acc(0, 8'h38, 8'h00, rd, st);
        acc(1, 8'hF8, 8'h77, rd, st);
        mem_lat = 1;
        base = xlog.size();
        do_flush(pulses, bw_low);
        chk("flush_pulses", pulses, 1);
        chk("flush_busy", bw_low, 0);
        chk("flush_xfers", xlog.size() - base, 3);
        chk("flush0_addr", {xlog[base].wr, xlog[base].addr}, {1'b1, 6'h00});
        chk("flush0_data", xlog[base].data, refblk(8'h00));
        chk("flush1_addr", {xlog[base+1].wr, xlog[base+1].addr}, {1'b1, 6'h09});
        chk("flush1_data", xlog[base+1].data, refblk(8'h09));
        chk("flush2_addr", {xlog[base+2].wr, xlog[base+2].addr}, {1'b1, 6'h3E});
        chk("flush2_data", xlog[base+2].data, refblk(8'h3E));
        chk("flush_dirty_clear", dut.dirty_q, 0);
        acc(0, 8'h25, 8'h00, rd, st);
        chk("postflush_stall", st, 0);
        chk("postflush_data", rd, 8'hAB);
        acc(0, 8'hFA, 8'h00, rd, st);
        chk("postflush_stall2", st, 0);

        // Random conflict traffic against the reference image
        for (int n = 0; n < 200; n++) begin
            wr = 1'($urandom_range(0, 1));
            mem_lat = $urandom_range(0, 2);
            case ($urandom_range(0, 3))
                0: a = {4'h1, 2'b00, 2'($urandom_range(0, 3))};
                1: a = {4'h3, 2'b00, 2'($urandom_range(0, 3))};
                2: a = {4'h6, 2'b00, 2'($urandom_range(0, 3))};
                default: a = {4'($urandom_range(0, 15)), 2'b11, 2'($urandom_range(0, 3))};
            endcase
            acc(wr, a, 8'($urandom), rd, st);
            if (!wr) chk("rand_rd", rd, refm[a]);
        end
        do_flush(pulses, bw_low);
        chk("final_flush_pulses", pulses, 1);
        bad = 0;
        for (int b = 0; b < 64; b++) if (mem[b] !== refblk(b)) bad++;
        chk("mem_image", bad, 0);

        // Reset in the middle of a fetch
        mem_lat = 8;
        @(negedge clock);
        address = 8'hE8; read = 1'b1;
        #1;
        cyc = 0;
        while (!mem_read && cyc < 20) begin
            @(negedge clock); #1; cyc++;
        end
        chk("rst_fetch_seen", mem_read, 1);
        #2; reset = 1'b0; #1;
        chk("midrst_mem_read", mem_read, 0);
        chk("midrst_busywait", busywait, 0);
        chk("midrst_mem_write", mem_write, 0);
        @(negedge clock); read = 1'b0;
        #2; reset = 1'b1;
        mem_lat = 1;
        acc(0, 8'h24, 8'h00, rd, st);
        chk("postrst_miss_stall", st, 4);
        chk("postrst_data", rd, refm[8'h24]);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/dcache_assoc.md
Name: dcache_assoc

Overview:
- Parametrised 2-way set-associative, write-back, write-allocate data cache; next generation of the direct-mapped data cache.
- Sits between the CPU load/store path (8-bit word interface) and the block-wide data memory.
- Adds configurable address, word, block and set sizes, LRU replacement, zero-wait-state hits, and a flush operation that writes back all dirty lines.

Parameters:
- ADDR_W, 8: CPU byte/word address width.
- WORD_W, 8: CPU data word width.
- WORDS, 4: words per block; power of 2, >=2.
- SETS, 4: number of sets; power of 2, >=2.
- Derived widths:
  - OFF_W = log2(WORDS).
  - IDX_W = log2(SETS).
  - TAG_W = ADDR_W-IDX_W-OFF_W.
  - BLK_W = WORD_W*WORDS.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- read  in  1  CPU read request; level, held until busywait low.
- write  in  1  CPU write request; level, held until busywait low.
- address  in  ADDR_W  {tag, index, offset}.
- writedata  in  WORD_W  store data.
- readdata  out  WORD_W  load data.
- busywait  out  1  CPU stall.
- flush  in  1  flush request; level, held until flush_done.
- flush_done  out  1  one-cycle pulse when flush completes.
- mem_read  out  1  block read request.
- mem_write  out  1  block write request.
- mem_address  out  ADDR_W-OFF_W  block address {tag, index}.
- mem_writedata  out  BLK_W  block write data.
- mem_readdata  in  BLK_W  block read data.
- mem_busywait  in  1  memory stall; transfer completes on the first posedge where it is sampled 0 with a request high.

Behaviour:
- Storage per set and way: valid, dirty, tag, block. One LRU bit per set (value = least-recently-used way).
- Reset (reset=0, async):
  - State goes to IDLE.
  - All valid, dirty and LRU bits clear; flush counter is 0.
  - Outputs: busywait=0, flush_done=0, mem_read=0, mem_write=0, readdata=0, mem_address=0, mem_writedata=0.
  - Data arrays are not cleared.
  - Reset mid-transfer aborts the transfer immediately; memory must tolerate a dropped request.
- Request priority: if read and write are both high, the access is a write. Flush is accepted only in IDLE with read=write=0.
- Hit: valid & tag match in either way. Both ways are compared combinationally.
  - Read hit: readdata = selected word of the hit block, combinational; busywait=0 in the same cycle (zero wait states).
  - Write hit: busywait=0. At the posedge the word is written, dirty=1, LRU points to the other way.
  - Any hit updates LRU at the posedge.
- Miss: busywait=1 combinationally while (read|write) & !hit, and in every non-IDLE state.
  - Victim selection: first invalid way, way0 preferred; otherwise the LRU way.
- FSM states: IDLE, WBACK, FETCH, ALLOC, FLUSH_SCAN, FLUSH_WB, FLUSH_DONE.
  - IDLE -> WBACK on miss with dirty victim.
  - IDLE -> FETCH on miss with clean or invalid victim.
  - IDLE -> FLUSH_SCAN on accepted flush.
  - WBACK: mem_write=1, mem_address={victim tag, index}, mem_writedata=victim block. On completion: victim dirty=0, go to FETCH.
  - FETCH: mem_read=1, mem_address={req tag, index}. On completion: latch mem_readdata, go to ALLOC.
  - ALLOC (1 cycle): victim block <= fetched data, tag <= req tag, valid=1, dirty=0; go to IDLE. The access re-evaluates as a hit in the next cycle (write hits then merge).
  - Miss latency with mem_busywait held high N cycles per transfer: clean miss = N+3 cycles of busywait; dirty miss = 2N+4 cycles.
- Memory outputs outside WBACK, FETCH and FLUSH_WB: mem_read=0, mem_write=0; address and data hold their last values (no X).
- Flush:
  - Counter walks entries (set, way) from 0 to 2*SETS-1, one entry per cycle in FLUSH_SCAN.
  - A valid & dirty entry goes to FLUSH_WB: write back, then dirty=0; valid and LRU are kept.
  - After the last entry: FLUSH_DONE asserts flush_done for one cycle, then IDLE.
  - busywait=1 throughout. CPU requests arriving during a flush are held off and served afterwards.
- Address and writedata must be stable while busywait=1. The cache latches only the fetched block, not the request.

Test Plan:
- Cold read 0x24 (tag 2, idx 1, off 0), mem_readdata=0x44332211, mem_busywait high 3 cycles -> mem_read with mem_address=0x09, busywait 6 cycles, then readdata=0x11; a follow-up read of 0x27 returns 0x44 with busywait=0.
- Write hit 0x25 data 0xAB after the fill above -> busywait never rises; a read of 0x25 returns 0xAB; set 1 way0 dirty.
- Fill set 1 both ways with tags 2 and 5, touch tag 2, then read tag 9 -> way1 (tag 5) evicted; if it was dirty, mem_write with mem_address=0x15 precedes mem_read with mem_address=0x25.
- Dirty-eviction conflict: three tags alternating in set 0 -> every miss with a dirty victim writes back the correct block; data readback matches a reference model over 200 random accesses.
- Flush with 3 dirty lines -> exactly 3 mem_write transfers in ascending (set, way) order; flush_done pulses once; all dirty bits 0; valid lines still hit.
- Assert reset=0 mid-FETCH -> mem_read and busywait drop immediately (asynchronously); after release, a read of the previously resident address misses.
